// File: rtl/wasm_cpu.sv
// wasm_cpu: small WebAssembly bytecode interpreter core.
//
// Executes a subset of WebAssembly (nop, unreachable, end, drop, i32/i64.const,
// i32/i64 add/sub, i32.eqz) from a byte-addressed ROM, starting at address 0.
// Operands live on an internal stack of 2**STACK_DEPTH 64-bit entries.
//
// Ports:
//   clk          sole clock, rising edge
//   reset        synchronous, active-low
//   result       registered top-of-stack value, 0 when the stack is empty
//   result_empty registered, 1 when the stack is empty
//   trap         status: 0 running, 1 end, 2 unreachable, 3 bad opcode / LEB
//                too long, 4 ROM out of bounds, 5 stack underflow,
//                6 stack overflow
//   mem_addr     ROM byte address (always equal to the program counter)
//   mem_extra    extra bytes requested, constant 0
//   mem_data     ROM data, addressed byte in [127:120]
//   mem_error    ROM out-of-bounds flag, arrives with mem_data
//   dbg_state    current FSM state, for observation only
//
// ROM interface: there is no valid/ready handshake. The ROM is fixed-latency:
// the address presented during cycle N is answered by mem_data/mem_error
// during cycle N+1, and the core samples them at the end of that cycle.
module wasm_cpu #(
  parameter int MEM_DEPTH   = 32,
  parameter int STACK_DEPTH = 4
) (
  input  logic               clk,
  input  logic               reset,
  output logic [63:0]        result,
  output logic               result_empty,
  output logic [3:0]         trap,
  output logic [MEM_DEPTH:0] mem_addr,
  output logic [3:0]         mem_extra,
  input  logic [127:0]       mem_data,
  input  logic               mem_error,
  output logic [2:0]         dbg_state
);

  localparam int STACK_SIZE = 1 << STACK_DEPTH;
  localparam logic [STACK_DEPTH:0] SP_FULL = (STACK_DEPTH+1)'(STACK_SIZE);
  localparam logic [STACK_DEPTH:0] SP_ONE  = (STACK_DEPTH+1)'(1);
  localparam logic [STACK_DEPTH:0] SP_TWO  = (STACK_DEPTH+1)'(2);
  localparam logic [MEM_DEPTH:0]   PC_ONE  = (MEM_DEPTH+1)'(1);

  typedef enum logic [2:0] {
    S_FETCH    = 3'd0,
    S_DECODE   = 3'd1,
    S_LEB      = 3'd2,
    S_LEB_WAIT = 3'd3,
    S_EXEC     = 3'd4,
    S_HALT     = 3'd5
  } state_t;

  state_t               state, state_n;
  logic [MEM_DEPTH:0]   pc, pc_n;
  logic [7:0]           opcode, opcode_n;
  logic [63:0]          leb_val, leb_val_n;
  logic [6:0]           leb_shift, leb_shift_n;
  logic [3:0]           leb_cnt, leb_cnt_n;
  logic [3:0]           trap_n;
  logic [STACK_DEPTH:0] sp, sp_n;
  logic [63:0]          result_n;
  logic                 result_empty_n;

  logic [63:0]            stk [STACK_SIZE];
  logic                   stk_we;
  logic [STACK_DEPTH-1:0] stk_widx;
  logic [63:0]            stk_wdata;

  logic [STACK_DEPTH-1:0] top_idx, sec_idx;
  logic [63:0]            top_val, sec_val;
  logic [7:0]             mem_byte;
  logic [3:0]             leb_limit;
  logic                   unused_mem_bits;

  assign mem_byte        = mem_data[127:120];
  assign unused_mem_bits = ^mem_data[119:0];
  assign mem_addr        = pc;
  assign mem_extra       = 4'd0;
  assign dbg_state       = state;

  // Slot indices wrap harmlessly when sp is too small; every use is guarded
  // by an sp check first.
  assign top_idx   = STACK_DEPTH'(sp - SP_ONE);
  assign sec_idx   = STACK_DEPTH'(sp - SP_TWO);
  assign top_val   = stk[top_idx];
  assign sec_val   = stk[sec_idx];
  assign leb_limit = (opcode == 8'h41) ? 4'd5 : 4'd10;

  always_comb begin
    state_n        = state;
    pc_n           = pc;
    opcode_n       = opcode;
    leb_val_n      = leb_val;
    leb_shift_n    = leb_shift;
    leb_cnt_n      = leb_cnt;
    trap_n         = trap;
    sp_n           = sp;
    result_n       = result;
    result_empty_n = result_empty;
    stk_we         = 1'b0;
    stk_widx       = top_idx;
    stk_wdata      = 64'd0;

    case (state)
      S_FETCH: state_n = S_DECODE;

      S_DECODE: begin
        if (mem_error) begin
          trap_n  = 4'd4;
          state_n = S_HALT;
        end else begin
          opcode_n = mem_byte;
          pc_n     = pc + PC_ONE;
          case (mem_byte)
            8'h41, 8'h42: begin
              leb_val_n   = 64'd0;
              leb_shift_n = 7'd0;
              leb_cnt_n   = 4'd0;
              state_n     = S_LEB;
            end
            8'h00, 8'h01, 8'h0B, 8'h1A, 8'h45,
            8'h6A, 8'h6B, 8'h7C, 8'h7D: state_n = S_EXEC;
            default: begin
              trap_n  = 4'd3;
              state_n = S_HALT;
            end
          endcase
        end
      end

      S_LEB: state_n = S_LEB_WAIT;

      S_LEB_WAIT: begin
        if (mem_error) begin
          trap_n  = 4'd4;
          state_n = S_HALT;
        end else begin
          pc_n        = pc + PC_ONE;
          leb_val_n   = leb_val | (64'(mem_byte[6:0]) << leb_shift);
          leb_shift_n = leb_shift + 7'd7;
          leb_cnt_n   = leb_cnt + 4'd1;
          if (mem_byte[7]) begin
            // Continuation on the last allowed byte means the immediate
            // is too long.
            if (leb_cnt_n == leb_limit) begin
              trap_n  = 4'd3;
              state_n = S_HALT;
            end else begin
              state_n = S_LEB;
            end
          end else begin
            if (mem_byte[6] && (leb_shift_n < 7'd64))
              leb_val_n = leb_val_n | ({64{1'b1}} << leb_shift_n);
            if (opcode == 8'h41)
              leb_val_n = {32'd0, leb_val_n[31:0]};
            state_n = S_EXEC;
          end
        end
      end

      S_EXEC: begin
        state_n = S_FETCH;
        case (opcode)
          8'h00: begin
            trap_n  = 4'd2;
            state_n = S_HALT;
          end
          8'h0B: begin
            trap_n  = 4'd1;
            state_n = S_HALT;
          end
          8'h1A: begin
            if (sp < SP_ONE) begin
              trap_n  = 4'd5;
              state_n = S_HALT;
            end else begin
              sp_n           = sp - SP_ONE;
              result_empty_n = (sp == SP_ONE);
              result_n       = (sp == SP_ONE) ? 64'd0 : sec_val;
            end
          end
          8'h41, 8'h42: begin
            if (sp == SP_FULL) begin
              trap_n  = 4'd6;
              state_n = S_HALT;
            end else begin
              stk_we         = 1'b1;
              stk_widx       = sp[STACK_DEPTH-1:0];
              stk_wdata      = leb_val;
              sp_n           = sp + SP_ONE;
              result_n       = leb_val;
              result_empty_n = 1'b0;
            end
          end
          8'h45: begin
            if (sp < SP_ONE) begin
              trap_n  = 4'd5;
              state_n = S_HALT;
            end else begin
              stk_we    = 1'b1;
              stk_widx  = top_idx;
              stk_wdata = {63'd0, (top_val[31:0] == 32'd0)};
              result_n  = stk_wdata;
            end
          end
          8'h6A, 8'h6B, 8'h7C, 8'h7D: begin
            if (sp < SP_TWO) begin
              trap_n  = 4'd5;
              state_n = S_HALT;
            end else begin
              // a is the second entry, b the top; the result overwrites a.
              case (opcode)
                8'h6A:   stk_wdata = {32'd0, sec_val[31:0] + top_val[31:0]};
                8'h6B:   stk_wdata = {32'd0, sec_val[31:0] - top_val[31:0]};
                8'h7C:   stk_wdata = sec_val + top_val;
                default: stk_wdata = sec_val - top_val;
              endcase
              stk_we   = 1'b1;
              stk_widx = sec_idx;
              sp_n     = sp - SP_ONE;
              result_n = stk_wdata;
            end
          end
          default: ; // nop
        endcase
      end

      default: ; // S_HALT: everything frozen until reset
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= S_FETCH;
      pc           <= '0;
      opcode       <= 8'd0;
      leb_val      <= 64'd0;
      leb_shift    <= 7'd0;
      leb_cnt      <= 4'd0;
      trap         <= 4'd0;
      sp           <= '0;
      result       <= 64'd0;
      result_empty <= 1'b1;
    end else begin
      state        <= state_n;
      pc           <= pc_n;
      opcode       <= opcode_n;
      leb_val      <= leb_val_n;
      leb_shift    <= leb_shift_n;
      leb_cnt      <= leb_cnt_n;
      trap         <= trap_n;
      sp           <= sp_n;
      result       <= result_n;
      result_empty <= result_empty_n;
      if (stk_we) stk[stk_widx] <= stk_wdata;
    end
  end

endmodule

// File: tb/tb_wasm_cpu.sv
// tb_wasm_cpu: self-checking bench for wasm_cpu. Directed programs plus
// randomized programs checked against an instruction-level interpreter.
module tb_wasm_cpu;

  localparam int MEM_DEPTH   = 32;
  localparam int STACK_DEPTH = 4;
  localparam int STACK_SIZE  = 1 << STACK_DEPTH;
  localparam int ROM_SIZE    = 512;
  localparam int MAX_CYCLES  = 4000;

  logic                 clk = 1'b0;
  logic                 reset = 1'b0;
  logic [63:0]          result;
  logic                 result_empty;
  logic [3:0]           trap;
  logic [MEM_DEPTH:0]   mem_addr;
  logic [3:0]           mem_extra;
  logic [127:0]         mem_data = '0;
  logic                 mem_error = 1'b0;
  logic [2:0]           dbg_state;

  logic [7:0] rom [ROM_SIZE];
  int         rom_len = 0;
  logic [63:0] exp_q[$];   // model operand stack, top at the back

  int checks = 0;
  int errors = 0;

  wasm_cpu #(.MEM_DEPTH(MEM_DEPTH), .STACK_DEPTH(STACK_DEPTH)) dut (
    .clk(clk), .reset(reset), .result(result), .result_empty(result_empty),
    .trap(trap), .mem_addr(mem_addr), .mem_extra(mem_extra),
    .mem_data(mem_data), .mem_error(mem_error), .dbg_state(dbg_state)
  );

  // ---------------- clock / ROM ----------------
  always #5 clk = ~clk;

  always @(posedge clk) begin
    mem_error <= (mem_addr >= (MEM_DEPTH+1)'(rom_len));
    mem_data  <= {rom[mem_addr[8:0]], $urandom(), $urandom(), $urandom(),
                  24'($urandom())};
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- program building ----------------
  task automatic clear_rom();
    for (int i = 0; i < ROM_SIZE; i++) rom[i] = 8'($urandom());
    rom_len = 0;
  endtask

  task automatic put(input logic [7:0] b);
    rom[rom_len] = b;
    rom_len++;
  endtask

  // Minimal signed LEB128 encoding.
  task automatic put_sleb(input longint v);
    longint     x;
    logic [7:0] b;
    bit         done;
    x = v;
    done = 0;
    while (!done) begin
      b = {1'b0, x[6:0]};
      x = x >>> 7;
      if ((x == 0 && !b[6]) || (x == -1 && b[6])) done = 1;
      else b[7] = 1'b1;
      put(b);
    end
  endtask

  // ---------------- reference interpreter ----------------
  task automatic model_run(output logic [3:0] t, output logic e,
                           output logic [63:0] r);
    int          pc;
    logic [7:0]  op, b;
    logic [63:0] va, vb, imm;
    int          sh, n, limit;
    bit          stop;
    exp_q.delete();
    pc = 0;
    t = 0;
    while (t == 0) begin
      if (pc >= rom_len) begin t = 4; break; end
      op = rom[pc];
      pc++;
      case (op)
        8'h00: t = 2;
        8'h0B: t = 1;
        8'h01: ;
        8'h1A: if (exp_q.size() < 1) t = 5; else void'(exp_q.pop_back());
        8'h41, 8'h42: begin
          limit = (op == 8'h41) ? 5 : 10;
          imm = 0; sh = 0; n = 0; stop = 0;
          while (!stop && t == 0) begin
            if (pc >= rom_len) begin t = 4; break; end
            b = rom[pc];
            pc++;
            n++;
            if (sh < 64) imm = imm | (64'(b[6:0]) << sh);
            sh += 7;
            if (b[7]) begin
              if (n == limit) t = 3;
            end else begin
              stop = 1;
            end
          end
          if (t == 0) begin
            if (b[6] && sh < 64) imm = imm | ({64{1'b1}} << sh);
            if (op == 8'h41) imm = imm & 64'hFFFF_FFFF;
            if (exp_q.size() == STACK_SIZE) t = 6;
            else exp_q.push_back(imm);
          end
        end
        8'h45: begin
          if (exp_q.size() < 1) t = 5;
          else begin
            va = exp_q.pop_back();
            exp_q.push_back((va[31:0] == 0) ? 64'd1 : 64'd0);
          end
        end
        8'h6A, 8'h6B, 8'h7C, 8'h7D: begin
          if (exp_q.size() < 2) t = 5;
          else begin
            vb = exp_q.pop_back();
            va = exp_q.pop_back();
            case (op)
              8'h6A:   exp_q.push_back((va + vb) % 64'h1_0000_0000);
              8'h6B:   exp_q.push_back((va - vb) & 64'hFFFF_FFFF);
              8'h7C:   exp_q.push_back(va + vb);
              default: exp_q.push_back(va - vb);
            endcase
          end
        end
        default: t = 3;
      endcase
    end
    e = (exp_q.size() == 0);
    r = e ? 64'd0 : exp_q[exp_q.size()-1];
  endtask

  // ---------------- driver ----------------
  task automatic expect_halt(input string tag, input logic [3:0] t,
                             input logic e, input logic [63:0] r);
    int cyc;
    @(negedge clk) reset = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    cyc = 0;
    while (trap == 4'd0 && cyc < MAX_CYCLES) begin
      @(negedge clk);
      cyc++;
    end
    check({tag, "_halted"}, 64'(trap != 4'd0), 64'd1);
    check({tag, "_trap"}, 64'(trap), 64'(t));
    check({tag, "_empty"}, 64'(result_empty), 64'(e));
    check({tag, "_result"}, result, r);
    repeat (5) @(negedge clk);
    check({tag, "_trap_frozen"}, 64'(trap), 64'(t));
    check({tag, "_result_frozen"}, result, r);
  endtask

  task automatic run_model_prog(input string tag);
    logic [3:0]  t;
    logic        e;
    logic [63:0] r;
    model_run(t, e, r);
    expect_halt(tag, t, e, r);
  endtask

  task automatic gen_random_prog();
    int   nops, k;
    logic [31:0] w;
    clear_rom();
    nops = $urandom_range(1, 24);
    for (int i = 0; i < nops; i++) begin
      k = $urandom_range(0, 99);
      if (k < 35) begin
        put(8'h41);
        if ($urandom_range(0, 2) == 0) put_sleb(longint'($urandom_range(0, 140)) - 70);
        else begin w = $urandom(); put_sleb(longint'(signed'(w))); end
      end else if (k < 50) begin
        put(8'h42);
        put_sleb(longint'({$urandom(), $urandom()}));
      end
      else if (k < 58) put(8'h6A);
      else if (k < 64) put(8'h6B);
      else if (k < 70) put(8'h7C);
      else if (k < 74) put(8'h7D);
      else if (k < 80) put(8'h45);
      else if (k < 86) put(8'h1A);
      else if (k < 92) put(8'h01);
      else if (k < 94) put(8'h00);
      else if (k < 96) put(8'($urandom()));
      else begin
        put(8'h41);
        for (int j = 0; j < 6; j++) put(8'h80);
      end
    end
    if ($urandom_range(0, 99) < 85) put(8'h0B);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    clear_rom();
    // Reset held for 9 cycles.
    reset = 1'b0;
    repeat (9) @(negedge clk);
    check("rst_empty", 64'(result_empty), 64'd1);
    check("rst_trap", 64'(trap), 64'd0);
    check("rst_result", result, 64'd0);
    check("rst_addr", 64'(mem_addr), 64'd0);
    check("rst_extra", 64'(mem_extra), 64'd0);

    clear_rom(); put(8'h41); put(8'h05); put(8'h1A); put(8'h0B);
    expect_halt("const_drop", 4'd1, 1'b1, 64'd0);

    clear_rom(); put(8'h41); put(8'h7F); put(8'h41); put(8'h02); put(8'h6A); put(8'h0B);
    expect_halt("i32_add_wrap", 4'd1, 1'b0, 64'h1);

    clear_rom(); put(8'h42); put(8'h7F); put(8'h0B);
    expect_halt("i64_neg1", 4'd1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF);

    clear_rom(); put(8'h1A); put(8'h0B);
    expect_halt("drop_empty", 4'd5, 1'b1, 64'd0);

    clear_rom(); put(8'hFF);
    expect_halt("bad_opcode", 4'd3, 1'b1, 64'd0);

    clear_rom(); put(8'h01); put(8'h01);
    expect_halt("rom_oob", 4'd4, 1'b1, 64'd0);

    clear_rom(); put(8'h00);
    expect_halt("unreachable", 4'd2, 1'b1, 64'd0);

    clear_rom(); put(8'h41); put(8'h00); put(8'h41); put(8'h01); put(8'h6B); put(8'h0B);
    expect_halt("i32_sub_wrap", 4'd1, 1'b0, 64'hFFFF_FFFF);

    clear_rom(); put(8'h42); put(8'h00); put(8'h42); put(8'h01); put(8'h7D); put(8'h0B);
    expect_halt("i64_sub_wrap", 4'd1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF);

    clear_rom(); put(8'h41); put(8'h80); put(8'h80); put(8'h80); put(8'h80); put(8'h80); put(8'h00);
    expect_halt("leb_too_long", 4'd3, 1'b1, 64'd0);

    clear_rom(); put(8'h41); put(8'hC0); put(8'hBB); put(8'h78); put(8'h45); put(8'h0B);
    expect_halt("eqz_nonzero", 4'd1, 1'b0, 64'd0);

    clear_rom();
    for (int i = 0; i <= STACK_SIZE; i++) begin put(8'h41); put(8'h01); end
    put(8'h0B);
    expect_halt("overflow", 4'd6, 1'b0, 64'd1);

    clear_rom(); put(8'h41); put(8'h05); put(8'h6A); put(8'h0B);
    expect_halt("add_underflow", 4'd5, 1'b0, 64'd5);

    // Reset asserted mid-program restores reset values at that edge.
    clear_rom(); put(8'h41); put(8'h05);
    for (int i = 0; i < 20; i++) put(8'h01);
    put(8'h0B);
    @(negedge clk) reset = 1'b0;
    @(negedge clk) reset = 1'b1;
    repeat (12) @(negedge clk);
    check("mid_pre_result", result, 64'd5);
    reset = 1'b0;
    @(negedge clk);
    check("mid_rst_result", result, 64'd0);
    check("mid_rst_empty", 64'(result_empty), 64'd1);
    check("mid_rst_addr", 64'(mem_addr), 64'd0);
    check("mid_rst_trap", 64'(trap), 64'd0);

    // Randomized programs against the interpreter.
    for (int n = 0; n < 60; n++) begin
      gen_random_prog();
      run_model_prog($sformatf("rand%0d", n));
    end

    // Reset from HALT.
    @(negedge clk) reset = 1'b0;
    @(negedge clk);
    check("halt_rst_trap", 64'(trap), 64'd0);
    check("halt_rst_empty", 64'(result_empty), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/wasm_cpu.md
WASM_CPU -- requirements
Module: wasm_cpu

Interface
REQ-001 SHALL have parameter MEM_DEPTH, default 32, meaning the ROM address MSB index; mem_addr is MEM_DEPTH+1 bits wide.
REQ-002 SHALL have parameter STACK_DEPTH, default 4, meaning the operand stack holds 2**STACK_DEPTH 64-bit entries.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-low reset; the core is held in reset while reset=0.
REQ-005 result  output  64  top-of-stack value; 0 when the stack is empty.
REQ-006 result_empty  output  1  1 when the operand stack is empty.
REQ-007 trap  output  4  status code; 0 = running.
REQ-008 mem_addr  output  MEM_DEPTH+1  byte address of the ROM read.
REQ-009 mem_extra  output  4  number of extra bytes requested; always driven 0.
REQ-010 mem_data  input  128  ROM data; the byte at mem_addr is in bits [127:120].
REQ-011 mem_error  input  1  ROM out-of-bounds flag, valid together with mem_data.

Function
REQ-012 SHALL treat ROM reads as 1-cycle latency: address driven in cycle N, data/error sampled in cycle N+1.
REQ-013 SHALL execute a WebAssembly bytecode subset starting at address 0, fetching one byte per read.
REQ-014 FSM states SHALL be FETCH -> DECODE -> (LEB -> LEB_WAIT)* -> EXEC -> FETCH, plus HALT.
- FETCH: drive mem_addr = pc.
- DECODE: latch the opcode byte; pc += 1.
REQ-015 Opcode 0x01 nop SHALL take no action.
REQ-016 Opcode 0x00 unreachable SHALL halt with trap=2.
REQ-017 Opcode 0x0B end SHALL halt with trap=1; the stack is left intact.
REQ-018 Opcode 0x1A drop SHALL pop one entry.
REQ-019 Opcode 0x41 i32.const SHALL read a signed LEB128 immediate of at most 5 bytes, one byte per read:
- bit 7 of each byte = continuation.
- pc advances per byte.
- value sign-extended from the final shift, truncated to 32 bits, zero-extended to 64 bits, then pushed.
REQ-020 Opcode 0x42 i64.const SHALL read the same way with at most 10 bytes and push the 64-bit value.
REQ-021 Opcode 0x6A i32.add and 0x6B i32.sub SHALL pop b then a, push (a op b) mod 2**32, zero-extended.
REQ-022 Opcode 0x7C i64.add and 0x7D i64.sub SHALL pop b then a, push (a op b) mod 2**64.
REQ-023 Opcode 0x45 i32.eqz SHALL replace the top entry with 1 if its low 32 bits are 0, else with 0.
REQ-024 Any other opcode SHALL halt with trap=3.
REQ-025 mem_error=1 on any sampled read SHALL halt with trap=4, taking precedence over decoding that byte.
REQ-026 Popping from an insufficient stack SHALL halt with trap=5; the stack is unchanged.
REQ-027 Pushing onto a full stack SHALL halt with trap=6.
REQ-028 A LEB immediate exceeding its byte limit SHALL halt with trap=3.
REQ-029 In HALT, all state SHALL freeze until reset; mem_addr holds its last value.
REQ-030 result and result_empty SHALL be registered and reflect the stack after each EXEC edge.

Reset
REQ-031 While reset=0 at a rising edge, the core SHALL set:
- pc=0, state=FETCH, stack pointer=0.
- trap=0, result=0, result_empty=1, mem_addr=0, mem_extra=0.
REQ-032 Reset asserted mid-instruction or in HALT SHALL abandon the instruction and restore the REQ-031 values at that edge.
REQ-033 Execution SHALL begin with FETCH on the first edge where reset=1.

Verification
REQ-034 Reset held low for 9 cycles -> result_empty=1, trap=0, result=0, mem_addr=0.
REQ-035 Program 41 05 1A 0B, reset released -> after end: result_empty=1, trap=1.
REQ-036 Program 41 7F 41 02 6A 0B -> result=0x0000_0000_0000_0001, result_empty=0, trap=1.
REQ-037 Program 42 7F 0B -> result=0xFFFF_FFFF_FFFF_FFFF, trap=1.
REQ-038 Program 1A 0B -> trap=5, result_empty=1.
REQ-039 Program FF -> trap=3. Program 01 01 with no end in a 2-byte ROM -> trap=4.
